// File: rtl/ps2_mouse_receiver.sv
// ps2_mouse_receiver: PS/2 device-to-host frame receiver delivering one byte plus parity/stop error flags per frame
module ps2_mouse_receiver #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       CLK_MOUSE_IN,
    input  logic       DATA_MOUSE_IN,
    input  logic       READ_ENABLE,
    output logic       BYTE_READ,
    output logic [7:0] BYTE,
    output logic [1:0] BYTE_ERROR_CODE,
    output logic       RX_BUSY
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP, DONE} state_t;
    state_t state, state_nxt;
    logic clk_s1, clk_s2, clk_prev, dat_s1, dat_s2, fe, tmo, parity_bit, stop_bit;
    logic [2:0] bit_cnt;
    logic [7:0] shift_reg;
    logic [TW-1:0] timeout_cnt;
    assign fe = clk_prev & ~clk_s2;
    assign tmo = timeout_cnt == TW'(TIMEOUT_CYCLES - 1);
    assign RX_BUSY = state != IDLE;
    // A falling edge always takes priority over an expiring timeout
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = (fe && READ_ENABLE && !dat_s2) ? DATA : IDLE;
            DATA:    state_nxt = fe ? (bit_cnt == 3'd7 ? PARITY : DATA) : tmo ? IDLE : DATA;
            PARITY:  state_nxt = fe ? STOP : tmo ? IDLE : PARITY;
            STOP:    state_nxt = fe ? DONE : tmo ? IDLE : STOP;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            clk_s1          <= 1'b1;
            clk_s2          <= 1'b1;
            clk_prev        <= 1'b1;
            dat_s1          <= 1'b1;
            dat_s2          <= 1'b1;
            state           <= IDLE;
            bit_cnt         <= '0;
            timeout_cnt     <= '0;
            shift_reg       <= '0;
            parity_bit      <= 1'b0;
            stop_bit        <= 1'b0;
            BYTE_READ       <= 1'b0;
            BYTE            <= '0;
            BYTE_ERROR_CODE <= '0;
        end else begin
            clk_s1      <= CLK_MOUSE_IN;
            clk_s2      <= clk_s1;
            clk_prev    <= clk_s2;
            dat_s1      <= DATA_MOUSE_IN;
            dat_s2      <= dat_s1;
            state       <= state_nxt;
            BYTE_READ   <= state == DONE;
            timeout_cnt <= (fe || state == IDLE) ? '0 : (&timeout_cnt ? timeout_cnt : timeout_cnt + 1'b1);
            bit_cnt     <= (state == DATA && fe) ? bit_cnt + 3'd1 : (state == IDLE || state_nxt == IDLE) ? 3'd0 : bit_cnt;
            if (state == DATA && fe)
                shift_reg[bit_cnt] <= dat_s2;
            if (state == PARITY && fe)
                parity_bit <= dat_s2;
            if (state == STOP && fe)
                stop_bit <= dat_s2;
            if (state == DONE) begin
                BYTE            <= shift_reg;
                BYTE_ERROR_CODE <= {~stop_bit, ~(^shift_reg ^ parity_bit)};
            end
        end
    end
endmodule

// File: tb/tb_ps2_mouse_receiver.sv
// tb_ps2_mouse_receiver: directed table, corner sequences and random frames checked against a frame-level model
module tb_ps2_mouse_receiver;
    localparam int TO = 64;
    logic CLK = 1'b0, RESET = 1'b0, CLK_MOUSE_IN = 1'b1, DATA_MOUSE_IN = 1'b1, READ_ENABLE = 1'b0;
    logic BYTE_READ, RX_BUSY, busy_seen = 1'b0;
    logic [7:0] BYTE, mdl_byte;
    logic [1:0] BYTE_ERROR_CODE, mdl_err;
    int cyc = 0, strobes = 0, strobe_cyc = 0, fall_cyc = 0, hp = 8, n_cmp = 0, n_bad = 0;

    typedef struct {
        logic [7:0] d;
        logic       par, stp, en, drop;
        int         n;
        logic [7:0] eb;
        logic [1:0] ee;
    } vec_t;
    vec_t tbl[5];

    ps2_mouse_receiver #(.TIMEOUT_CYCLES(TO)) dut (
        .CLK(CLK), .RESET(RESET), .CLK_MOUSE_IN(CLK_MOUSE_IN), .DATA_MOUSE_IN(DATA_MOUSE_IN),
        .READ_ENABLE(READ_ENABLE), .BYTE_READ(BYTE_READ), .BYTE(BYTE),
        .BYTE_ERROR_CODE(BYTE_ERROR_CODE), .RX_BUSY(RX_BUSY)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;
    always @(negedge CLK) begin
        if (BYTE_READ === 1'b1) begin
            strobes++;
            strobe_cyc = cyc;
        end
        if (RX_BUSY === 1'b1) busy_seen = 1'b1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic par, input logic stp, input int nbits, input logic drop);
        logic [10:0] f;
        f = {stp, par, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            DATA_MOUSE_IN = f[i];
            tick(hp);
            CLK_MOUSE_IN = 1'b0;
            fall_cyc = cyc;
            tick(hp);
            CLK_MOUSE_IN = 1'b1;
            if (drop && i == 0) READ_ENABLE = 1'b0;
        end
        tick(hp);
        DATA_MOUSE_IN = 1'b1;
    endtask

    task automatic run(input string nm, input logic [7:0] d, input logic par, input logic stp, input logic en,
                       input logic drop, input int exp_n, input logic [7:0] eb, input logic [1:0] ee);
        int s0;
        READ_ENABLE = en;
        s0 = strobes;
        busy_seen = 1'b0;
        send(d, par, stp, 11, drop);
        tick(6);
        check({nm, " strobes"}, strobes - s0, exp_n);
        if (exp_n == 1) check({nm, " latency"}, strobe_cyc - fall_cyc, 4);
        check({nm, " byte"}, int'(BYTE), int'(eb));
        check({nm, " err"}, int'(BYTE_ERROR_CODE), int'(ee));
        check({nm, " busy_after"}, int'(RX_BUSY), 0);
        check({nm, " busy_seen"}, int'(busy_seen), exp_n);
    endtask

    initial begin
        int s0;
        logic [7:0] d;
        logic par, stp, en, drop;
        tbl[0] = '{8'hFA, 1'b1, 1'b1, 1'b1, 1'b0, 1, 8'hFA, 2'b00};
        tbl[1] = '{8'hAA, 1'b0, 1'b1, 1'b1, 1'b0, 1, 8'hAA, 2'b01};
        tbl[2] = '{8'h08, 1'b0, 1'b0, 1'b1, 1'b0, 1, 8'h08, 2'b10};
        tbl[3] = '{8'h55, 1'b1, 1'b1, 1'b0, 1'b0, 0, 8'h08, 2'b10};
        tbl[4] = '{8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 1, 8'h3C, 2'b00};

        for (int i = 0; i < 5; i++) begin
            CLK_MOUSE_IN = 1'($urandom);
            DATA_MOUSE_IN = 1'($urandom);
            tick(1);
        end
        CLK_MOUSE_IN = 1'b1;
        DATA_MOUSE_IN = 1'b1;
        tick(1);
        check("reset byte_read", int'(BYTE_READ), 0);
        check("reset byte", int'(BYTE), 0);
        check("reset err", int'(BYTE_ERROR_CODE), 0);
        check("reset busy", int'(RX_BUSY), 0);
        check("reset strobes", strobes, 0);
        RESET = 1'b1;
        tick(4);

        for (int i = 0; i < 5; i++)
            run($sformatf("vec%0d", i), tbl[i].d, tbl[i].par, tbl[i].stp, tbl[i].en, tbl[i].drop,
                tbl[i].n, tbl[i].eb, tbl[i].ee);

        s0 = strobes;
        READ_ENABLE = 1'b1;
        send(8'h77, 1'b0, 1'b1, 6, 1'b0);
        tick(fall_cyc + 66 - cyc);
        check("timeout busy before limit", int'(RX_BUSY), 1);
        tick(1);
        check("timeout busy at limit", int'(RX_BUSY), 0);
        tick(10);
        check("timeout strobes", strobes - s0, 0);
        check("timeout byte held", int'(BYTE), 8'h3C);
        check("timeout err held", int'(BYTE_ERROR_CODE), 0);
        run("after_timeout", 8'h08, 1'b0, 1'b1, 1'b1, 1'b0, 1, 8'h08, 2'b00);

        s0 = strobes;
        send(8'h5A, 1'b0, 1'b1, 5, 1'b0);
        check("midreset busy before", int'(RX_BUSY), 1);
        RESET = 1'b0;
        tick(1);
        RESET = 1'b1;
        check("midreset busy after", int'(RX_BUSY), 0);
        check("midreset byte", int'(BYTE), 0);
        run("post_reset", 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1, 8'h00, 2'b00);
        check("midreset total strobes", strobes - s0, 1);

        mdl_byte = 8'h00;
        mdl_err = 2'b00;
        for (int i = 0; i < 30; i++) begin
            d = 8'($urandom);
            par = 1'($urandom);
            stp = $urandom_range(3) != 0;
            en = $urandom_range(3) != 0;
            drop = 1'($urandom);
            hp = $urandom_range(20, 4);
            if (en) begin
                mdl_byte = d;
                mdl_err = {~stp, par == ^d};
            end
            run($sformatf("rand%0d", i), d, par, stp, en, drop, en ? 1 : 0, mdl_byte, mdl_err);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
